// File: rtl/clock_sel_pkg.sv
// Shared encodings for the clock-select request sequencer.
package clock_sel_pkg;

   // Select codes understood by the downstream glitch-free clock switch
   localparam logic [1:0] SEL_800M  = 2'b00;
   localparam logic [1:0] SEL_500M  = 2'b01;
   localparam logic [1:0] SEL_1000M = 2'b10;
   localparam logic [1:0] SEL_RSVD  = 2'b11;

   // Sequencer states: waiting for a request, waiting for the switch to
   // settle, and enforcing the minimum spacing between switches
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DWELL  = 2'd2
   } state_t;

endpackage

// File: rtl/clock_sel_ctrl.sv
// Request sequencer in front of the clock switch: filters reserved and no-op
// requests, drives clk_sel, and spaces real switches by a settle + dwell window.
module clock_sel_ctrl
   import clock_sel_pkg::*;
#(
   parameter int         SETTLE_CYC = 8,
   parameter int         DWELL_CYC  = 32,
   parameter int         CNT_W      = 8,
   parameter logic [1:0] RST_SEL    = SEL_800M
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [1:0]       req_sel,
   output logic             req_ready,
   output logic [1:0]       clk_sel,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] sw_cnt
);

   // Counter only ever needs to reach DWELL_CYC; it restarts on every switch
   localparam int            CW         = $clog2(DWELL_CYC + 1);
   localparam logic [CW-1:0] SETTLE_LIM = CW'(SETTLE_CYC);
   localparam logic [CW-1:0] DWELL_LIM  = CW'(DWELL_CYC);

   state_t        state;
   logic [CW-1:0] cyc_cnt;
   logic [CW-1:0] cnt_nxt;
   logic          accept;

   assign req_ready = (state == ST_IDLE) && !rst;
   assign busy      = (state != ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign cnt_nxt   = cyc_cnt + 1'b1;

   // Sequencer FSM, window counter, select register and status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cyc_cnt <= '0;
         clk_sel <= RST_SEL;
         sw_cnt  <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (req_sel == SEL_RSVD) begin
                     err <= 1'b1;
                  end else if (req_sel == clk_sel) begin
                     // Already on the requested clock: complete immediately
                     done <= 1'b1;
                  end else begin
                     clk_sel <= req_sel;
                     cyc_cnt <= '0;
                     state   <= ST_SETTLE;
                  end
               end
            end
            ST_SETTLE: begin
               cyc_cnt <= cnt_nxt;
               if (cnt_nxt == SETTLE_LIM) begin
                  done   <= 1'b1;
                  sw_cnt <= sw_cnt + 1'b1;
                  // With no dwell beyond settle, go straight back to idle
                  state  <= (SETTLE_LIM == DWELL_LIM) ? ST_IDLE : ST_DWELL;
               end
            end
            ST_DWELL: begin
               cyc_cnt <= cnt_nxt;
               if (cnt_nxt == DWELL_LIM) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
